// File: rtl/fix_div.sv
// Sequential unsigned fixed-point divider: quotient = floor((dividend << Bf) / divisor),
// one restoring-division quotient bit per cycle, valid/ready handshakes on both sides.
module fix_div #(
  parameter int Bf              = 8,
  parameter int FIX_POINT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FIX_POINT_WIDTH-1:0] dividend,
  input  logic [FIX_POINT_WIDTH-1:0] divisor,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIX_POINT_WIDTH-1:0] quotient,
  output logic                       sat,
  output logic                       dz
);

  localparam int W  = FIX_POINT_WIDTH;
  localparam int QW = FIX_POINT_WIDTH + Bf;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [QW-1:0]   num;
  logic [W-1:0]    den;
  logic [W:0]      rem;
  logic [QW-1:0]   qreg;
  logic [CW-1:0]   cnt;

  logic [W:0]      trial;
  logic            trial_ge;
  logic [W:0]      rem_next;
  logic [QW-1:0]   qreg_next;
  logic            last_bit;
  logic            overflow;

  // One restoring step: shift the next numerator bit into the remainder and
  // subtract the divisor if it fits. R < D keeps the trial inside W+1 bits.
  always_comb begin
    trial     = {rem[W-1:0], num[cnt]};
    trial_ge  = (trial >= {1'b0, den});
    rem_next  = trial_ge ? (trial - {1'b0, den}) : trial;
    qreg_next = {qreg[QW-2:0], trial_ge};
    last_bit  = (cnt == '0);
    overflow  = |qreg_next[QW-1:W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Result registers only change on entry to DONE, so they hold through
  // backpressure and keep their value after the result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num      <= '0;
      den      <= '0;
      rem      <= '0;
      qreg     <= '0;
      cnt      <= '0;
      quotient <= '0;
      sat      <= 1'b0;
      dz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            num  <= {dividend, {Bf{1'b0}}};
            den  <= divisor;
            rem  <= '0;
            qreg <= '0;
            cnt  <= CW'(QW - 1);
            if (divisor == '0) begin
              quotient <= '1;
              sat      <= 1'b1;
              dz       <= 1'b1;
            end
          end
        end
        CALC: begin
          rem  <= rem_next;
          qreg <= qreg_next;
          if (last_bit) begin
            quotient <= overflow ? '1 : qreg_next[W-1:0];
            sat      <= overflow;
            dz       <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fix_div.sv
// Self-checking bench for fix_div: directed cases plus randomized operands,
// scoreboarded against an arithmetic model of the fixed-point division.
module tb_fix_div;

  localparam int W  = 16;
  localparam int BF = 8;
  localparam int QW = W + BF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  quotient;
  logic          sat;
  logic          dz;

  int     checks_total = 0;
  int     checks_passed = 0;
  longint cycle = 0;

  typedef struct {
    logic [W-1:0] q;
    logic         sat;
    logic         dz;
    longint       acc;
    bit           seen;
  } exp_t;

  exp_t exp_q[$];

  fix_div #(.Bf(BF), .FIX_POINT_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .sat       (sat),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
  endtask

  // Plain integer division of the scaled numerator, saturated to the word.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   r;
    longint n;
    longint q;
    r.acc  = 0;
    r.seen = 0;
    if (b == 0) begin
      r.q = '1; r.sat = 1'b1; r.dz = 1'b1;
    end else begin
      n = longint'(a) << BF;
      q = n / longint'(b);
      r.dz = 1'b0;
      if (q > 64'hFFFF) begin
        r.q = '1; r.sat = 1'b1;
      end else begin
        r.q = q[W-1:0]; r.sat = 1'b0;
      end
    end
    return r;
  endfunction

  // Scoreboard: every accepted pair becomes an expected result; every cycle
  // with out_valid is compared, including first-valid latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        checkOutput("in_ready_low_in_done", in_ready, 0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_valid", 1, 0);
        end else begin
          checkOutput("quotient", quotient, exp_q[0].q);
          checkOutput("sat", sat, exp_q[0].sat);
          checkOutput("dz", dz, exp_q[0].dz);
          if (!exp_q[0].seen) begin
            checkOutput("latency", cycle - exp_q[0].acc, exp_q[0].dz ? 1 : QW + 1);
            exp_q[0].seen = 1;
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end else if (exp_q.size() != 0 && exp_q[0].seen) begin
        checkOutput("out_valid_dropped_early", 0, 1);
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        e = model(dividend, divisor);
        e.acc = cycle;
        exp_q.push_back(e);
      end
    end
  end

  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(posedge clk); #2;
    in_valid = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 0, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
  endtask

  task automatic waitResult(input bit noise);
    int n = 0;
    while (!out_valid && n < 100) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
      end
      @(posedge clk); #2;
      n++;
    end
    in_valid = 1'b0;
    if (!out_valid) checkOutput("result_timeout", 0, 1);
  endtask

  task automatic consumeResult(input int hold);
    repeat (hold) begin
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input int hold, input bit noise);
    startOp(a, b);
    waitResult(noise);
    consumeResult(hold);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           sel;

    checkOutput("model_pin_3_div_2", model(16'h0300, 16'h0200).q, 16'h0180);
    checkOutput("model_pin_1_div_3", model(16'h0100, 16'h0300).q, 16'h0055);
    checkOutput("model_pin_ovf_sat", model(16'h8000, 16'h0040).sat, 1);
    checkOutput("model_pin_dz", model(16'h1234, 16'h0000).dz, 1);

    #3;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_sat", sat, 0);
    checkOutput("reset_dz", dz, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    applyStimulus(16'h0300, 16'h0200, 2, 0);
    checkOutput("held_q_3_div_2", quotient, 16'h0180);
    checkOutput("idle_after_consume", in_ready, 1);
    applyStimulus(16'h0100, 16'h0300, 0, 1);
    checkOutput("held_q_1_div_3", quotient, 16'h0055);
    applyStimulus(16'h8000, 16'h0040, 1, 0);
    checkOutput("held_q_ovf", quotient, 16'hFFFF);
    checkOutput("held_sat_ovf", sat, 1);
    checkOutput("held_dz_ovf", dz, 0);
    applyStimulus(16'h1234, 16'h0000, 0, 0);
    checkOutput("held_dz", dz, 1);

    // Abort mid-CALC: outputs return to reset values immediately.
    startOp(16'h1234, 16'h0100);
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_quotient", quotient, 0);
    checkOutput("abort_sat", sat, 0);
    checkOutput("abort_dz", dz, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    applyStimulus(16'h0200, 16'h0100, 0, 0);
    checkOutput("after_abort_q", quotient, 16'h0200);

    // Backpressure: result held, new request ignored until handoff completes.
    startOp(16'h0080, 16'h0100);
    waitResult(0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_quotient", quotient, 16'h0080);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
      in_valid = (i == 4);
      dividend = 16'h0300;
      divisor  = 16'h0100;
      @(posedge clk); #2;
    end
    in_valid = 1'b1; dividend = 16'h0400; divisor = 16'h0100; out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    checkOutput("handoff_out_valid", out_valid, 0);
    checkOutput("handoff_in_ready", in_ready, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    checkOutput("handoff_accepted", in_ready, 0);
    waitResult(0);
    checkOutput("handoff_q", quotient, 16'h0400);
    consumeResult(0);

    for (int k = 0; k < 150; k++) begin
      sel = int'($urandom_range(0, 9));
      ra  = 16'($urandom);
      if (sel == 0) rb = '0;
      else if (sel < 3) rb = 16'($urandom_range(1, 255));
      else rb = 16'($urandom);
      applyStimulus(ra, rb, int'($urandom_range(0, 3)), 1);
    end

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fix_div.md
Name: fix_div

Overview:
- Sequential unsigned fixed-point divider for the nonlinear function datapath. Format is Q(FIX_POINT_WIDTH-Bf).Bf.
- Computes quotient = floor((dividend << Bf) / divisor) by restoring division, one quotient bit per cycle.
- Each bit trial subtracts the shifted divisor from the partial remainder. This inverts the accumulate-by-power-of-two step used in the adder stage.
- Feeds normalisation paths such as softmax 1/sum and log-ratio terms. Uses valid/ready handshakes on both sides.

Parameters:
- Bf, 8, number of fractional bits in dividend, divisor and quotient.
- FIX_POINT_WIDTH, 16, total word width of all data ports.
- QW (localparam), FIX_POINT_WIDTH+Bf, number of quotient bits computed, which equals the number of iteration cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- dividend  input  FIX_POINT_WIDTH  numerator, unsigned Qm.Bf.
- divisor  input  FIX_POINT_WIDTH  denominator, unsigned Qm.Bf.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- quotient  output  FIX_POINT_WIDTH  result, unsigned Qm.Bf, truncated toward zero.
- sat  output  1  result saturated because of overflow or divide-by-zero.
- dz  output  1  divisor was zero.

Behaviour:
- Reset: async on rst_n low.
  - State goes to IDLE.
  - in_ready=1, out_valid=0, quotient=0, sat=0, dz=0.
  - Internal remainder, quotient register and counter all cleared.
  - Reset mid-CALC or mid-DONE discards the operation; no output is produced for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1:
    - Latch numerator N = {dividend, Bf zeros} (QW bits) and D = divisor.
    - Clear remainder R (FIX_POINT_WIDTH+1 bits) and the QW-bit quotient register.
    - Set counter = QW-1.
    - If divisor==0, go to DONE with quotient=all ones, sat=1, dz=1.
    - Otherwise go to CALC.
- CALC (in_ready=0), one edge per bit, MSB first:
  - Form T = {R[FIX_POINT_WIDTH-1:0], N[counter]}.
  - If T >= D: R = T - D and quotient bit = 1. Otherwise R = T and quotient bit = 0.
  - When counter==0 after processing, go to DONE. Otherwise decrement the counter.
  - Exactly QW CALC edges. out_valid is first high QW+1 cycles after the accept edge.
  - The divide-by-zero path gives out_valid 1 cycle after accept.
- Output formation on entry to DONE:
  - If any of quotient-register bits [QW-1:FIX_POINT_WIDTH] is set: quotient = all ones, sat=1, dz=0.
  - Otherwise quotient = low FIX_POINT_WIDTH bits, sat=0.
  - The remainder is discarded (truncation).
- DONE:
  - out_valid=1, in_ready=0.
  - quotient, sat and dz are held stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - quotient, sat and dz keep their last values until the next DONE.
  - No back-to-back accept in the handoff cycle: in_ready rises only in the cycle after the result is consumed. Throughput is one result per QW+2 cycles minimum.
- Inputs are ignored outside IDLE. in_valid held high during CALC or DONE has no effect.
- Arithmetic rules:
  - All values are unsigned.
  - The T >= D compare is FIX_POINT_WIDTH+1 bits wide, so R < D always holds.
  - The subtract never wraps.

Test Plan:
- Reset, then dividend=0x0300 (3.0), divisor=0x0200 (2.0) -> out_valid 25 cycles after accept, quotient=0x0180 (1.5), sat=0, dz=0.
- dividend=0x0100 (1.0), divisor=0x0300 (3.0) -> quotient=0x0055 (truncated 0.332), sat=0.
- dividend=0x8000 (128.0), divisor=0x0040 (0.25) -> true result 512.0 overflows -> quotient=0xFFFF, sat=1, dz=0.
- dividend=0x1234, divisor=0x0000 -> out_valid 1 cycle after accept, quotient=0xFFFF, sat=1, dz=1.
- Backpressure check, using dividend=0x0080, divisor=0x0100:
  - Hold out_ready=0 for 10 cycles after out_valid -> quotient=0x0080 stable and in_ready=0 throughout.
  - Pulse a new in_valid meanwhile -> it is not accepted.
  - Raise out_ready -> IDLE next cycle, then the new operand is accepted.
- Assert rst_n=0 at CALC iteration 12 -> outputs immediately at reset values.
  - Release reset and issue 0x0200/0x0100 -> quotient=0x0200, no residue from the aborted operation.
